// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan controller for an up-to-8-digit time-multiplexed seven-segment
//   display. It steps a digit select through the digits, one digit per
//   refresh slot of CLK_DIV cycles. It also drives the matching active-low
//   anode enables. Each slot opens with BLANK_CYC cycles in which every anode
//   is off, which suppresses ghosting while the digit mux settles.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-high, priority over en
//   en          in   1  scan enable; 0 freezes the scan position and darkens
//   digit_mask  in   8  per-digit enable; bit k = 0 keeps anode k off
//   sel3        out  3  digit select to the 8:1 digit mux
//   an          out  8  anode enables, active-low (one low bit or all ones)
//   tick        out  1  pulse in the first cycle of each new slot
//   frame       out  1  pulse when slot 0 begins after a wrap
//
// Handshake: there is none. en is a level qualifier sampled every edge, and
// digit_mask is sampled at the same edge as the slot it affects.
module seg_scan_ctrl #(
   parameter int CLK_DIV    = 100000,
   parameter int BLANK_CYC  = 1000,
   parameter int NUM_DIGITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] digit_mask,
   output logic [2:0] sel3,
   output logic [7:0] an,
   output logic       tick,
   output logic       frame
);

   localparam int             CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [2:0]     SEL_LAST = 3'(NUM_DIGITS - 1);

   // Per-slot display state, derived from the next slot count.
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_ON    = 1'b1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    sel_nxt;
   logic          slot_wrap;
   logic          in_blank;
   logic [0:0]    state_nxt;
   logic [7:0]    an_nxt;

   // The outputs are decoded from the next count and select. This makes an,
   // sel3 and tick describe the same cycle after the edge.
   always_comb begin
      slot_wrap = en && (cnt == CNT_LAST);
      cnt_nxt   = cnt;
      sel_nxt   = sel3;
      if (en) begin
         if (slot_wrap) begin
            cnt_nxt = '0;
            sel_nxt = (sel3 == SEL_LAST) ? 3'd0 : sel3 + 3'd1;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   // A zero-length blanking interval removes the BLANK state entirely.
   generate
      if (BLANK_CYC == 0) begin : g_noblank
         assign in_blank = 1'b0;
      end else begin : g_blank
         localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
         assign in_blank = (cnt_nxt < BLANK_V);
      end
   endgenerate

   always_comb begin
      state_nxt = in_blank ? ST_BLANK : ST_ON;
      an_nxt    = 8'hFF;
      // sel_nxt never reaches NUM_DIGITS, so unused anodes stay high.
      if (en && (state_nxt == ST_ON) && digit_mask[sel_nxt]) begin
         an_nxt = ~(8'h01 << sel_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         sel3  <= 3'd0;
         an    <= 8'hFF;
         tick  <= 1'b0;
         frame <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         sel3  <= sel_nxt;
         an    <= an_nxt;
         tick  <= slot_wrap;
         frame <= slot_wrap && (sel_nxt == 3'd0);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl. It runs two instances (8 and 5 digits) from one
// stimulus stream. A position-based model checks every cycle: the count of
// enabled cycles since reset fixes the slot, the digit and the offset within
// the slot. Directed runs pin that model with literal values.
module tb_seg_scan_ctrl;

   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [7:0] digit_mask = 8'hFF;

   logic [2:0] sel8, sel5;
   logic [7:0] an8, an5;
   logic       tick8, tick5, frame8, frame5;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .NUM_DIGITS(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
      .sel3(sel8), .an(an8), .tick(tick8), .frame(frame8));

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .NUM_DIGITS(5)) dut5 (
      .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
      .sel3(sel5), .an(an5), .tick(tick5), .frame(frame5));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         pos       = 0;     // enabled cycles since reset
   bit         model_on  = 1'b0;
   bit         m_active  = 1'b0;  // last edge advanced the scan
   logic [7:0] m_mask    = 8'hFF;

   always @(posedge clk) begin
      if (rst) begin
         pos      = 0;
         model_on = 1'b1;
         m_active = 1'b0;
      end else if (en) begin
         pos      = pos + 1;
         m_active = 1'b1;
         m_mask   = digit_mask;
      end else begin
         m_active = 1'b0;
      end
   end

   function automatic logic [2:0] exp_sel(input int p, input int nd);
      return 3'((p / CLK_DIV) % nd);
   endfunction

   function automatic logic [7:0] exp_an(input bit act, input int p, input int nd,
                                         input logic [7:0] mask);
      int         s;
      logic [7:0] one;
      one = 8'h01;
      s   = (p / CLK_DIV) % nd;
      if (!act || (p % CLK_DIV) < BLANK_CYC || !mask[s]) return 8'hFF;
      return ~(one << s);
   endfunction

   function automatic logic exp_tick(input bit act, input int p);
      return act && (p % CLK_DIV == 0);
   endfunction

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (model_on) begin
         check("sel8",   sel8,   exp_sel(pos, 8));
         check("an8",    an8,    exp_an(m_active, pos, 8, m_mask));
         check("tick8",  tick8,  exp_tick(m_active, pos));
         check("frame8", frame8, exp_tick(m_active, pos) && exp_sel(pos, 8) == 3'd0);
         check("sel5",   sel5,   exp_sel(pos, 5));
         check("an5",    an5,    exp_an(m_active, pos, 5, m_mask));
         check("tick5",  tick5,  exp_tick(m_active, pos));
         check("frame5", frame5, exp_tick(m_active, pos) && exp_sel(pos, 5) == 3'd0);
         check("an5_hi", an5[7:5], 3'b111);
      end
   end

   // ---------------- driver helpers ----------------
   // Inputs change on the falling edge, well away from the sampling edge.
   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   logic [7:0] t1_an  [8] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};
   logic [2:0] t1_sel [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
   logic       t1_tick[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   int n_frame8, n_tick8, n_frame5, first_frame5;

   initial begin
      // Reset for 2 cycles, then start with all digits enabled.
      rst = 1'b1;
      en  = 1'b0;
      digit_mask = 8'hFF;
      run(2);
      rst = 1'b0;
      check("rst_sel", sel8, 3'd0);
      check("rst_an",  an8,  8'hFF);
      check("rst_tick", tick8, 1'b0);
      check("rst_frame", frame8, 1'b0);

      // First slots after reset: literal sequence.
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         check("t1_an",   an8,   t1_an[i]);
         check("t1_sel",  sel8,  t1_sel[i]);
         check("t1_tick", tick8, t1_tick[i]);
      end

      // Advance to digit 3, offset 2, then freeze for 10 cycles.
      run(7);
      check("t5_pre_sel", sel8, 3'd3);
      check("t5_pre_an",  an8,  8'hF7);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t5_hold_sel",  sel8,  3'd3);
         check("t5_hold_an",   an8,   8'hFF);
         check("t5_hold_tick", tick8, 1'b0);
      end
      en = 1'b1;
      @(negedge clk);
      check("t5_resume_an",  an8,  8'hF7);
      check("t5_resume_sel", sel8, 3'd3);
      @(negedge clk);
      check("t5_next_sel",  sel8,  3'd4);
      check("t5_next_tick", tick8, 1'b1);
      check("t5_next_an",   an8,   8'hFF);

      // Full frame counts from reset: 8 ticks and 1 frame in 32 cycles;
      // the 5-digit frame lands every 20 cycles.
      do_reset();
      en = 1'b1;
      n_frame8 = 0; n_tick8 = 0; n_frame5 = 0; first_frame5 = -1;
      for (int p = 1; p <= 40; p++) begin
         @(negedge clk);
         if (p <= 32) begin
            n_frame8 += int'(frame8);
            n_tick8  += int'(tick8);
         end
         if (frame5) begin
            n_frame5++;
            if (first_frame5 < 0) first_frame5 = p;
         end
      end
      check("t2_frames8", n_frame8, 1);
      check("t2_ticks8",  n_tick8,  8);
      check("t4_frames5", n_frame5, 2);
      check("t4_first5",  first_frame5, 20);

      // Masked digit 2 stays dark for its whole slot.
      do_reset();
      en = 1'b1;
      digit_mask = 8'b1111_1011;
      for (int p = 1; p <= 16; p++) begin
         @(negedge clk);
         if (p >= 8 && p <= 11) check("t3_an_dark", an8, 8'hFF);
         if (p == 8)  check("t3_tick", tick8, 1'b1);
         if (p == 13) check("t3_an3", an8, 8'hF7);
      end
      digit_mask = 8'hFF;

      // Reset in the ON state of digit 5.
      do_reset();
      en = 1'b1;
      run(21);
      check("t6_pre_an", an8, 8'hDF);
      rst = 1'b1;
      @(negedge clk);
      check("t6_sel",   sel8,   3'd0);
      check("t6_an",    an8,    8'hFF);
      check("t6_tick",  tick8,  1'b0);
      check("t6_frame", frame8, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("t6_resume_an", an8, 8'hFE);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) digit_mask = 8'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      en  = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
